// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: exception codes, control
// register addresses, FSM states and the trap-cause helper.
package pipe_ctrl_pkg;

  localparam logic [2:0] EXP_NONE    = 3'd0;
  localparam logic [2:0] EXP_ILL     = 3'd1;
  localparam logic [2:0] EXP_ALIGN   = 3'd2;
  localparam logic [2:0] EXP_SYSCALL = 3'd3;
  localparam logic [2:0] EXP_OVF     = 3'd4;
  localparam logic [2:0] EXP_INT     = 3'd7;

  localparam logic [1:0] CR_STATUS = 2'd0;
  localparam logic [1:0] CR_EPC    = 2'd1;
  localparam logic [1:0] CR_CAUSE  = 2'd2;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  // Bit order in both vectors: [3]=IF, [2]=ID, [1]=EX, [0]=MEM.
  typedef struct packed {
    logic [3:0] stall;
    logic [3:0] flush;
  } stage_ctrl_t;

  // A synchronous exception code wins; otherwise the trap came from the interrupt.
  function automatic logic [2:0] trap_cause(input logic [2:0] exp_code);
    return (exp_code != EXP_NONE) ? exp_code : EXP_INT;
  endfunction

endpackage

// File: rtl/pipe_ctrl_cr.sv
// Exception/control register file: EPC, cause, interrupt enable and the saved
// previous enable, plus the combinational control-register read port.
module pipe_ctrl_cr
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_trap,
  input  logic              i_eret,
  input  logic [2:0]        i_mem_exp,
  input  logic [ADDR_W-1:0] i_mem_pc,
  input  logic              i_cr_we,
  input  logic [1:0]        i_cr_addr,
  input  logic [31:0]       i_cr_wdata,
  output logic [ADDR_W-1:0] o_epc,
  output logic              o_int_en,
  output logic [31:0]       o_cr_rdata
);

  logic [ADDR_W-1:0] r_epc;
  logic [2:0]        r_cause;
  logic              r_int_en;
  logic              r_pie;

  // Trap and eret are mutually exclusive; the top only asserts i_cr_we when neither is taken.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_epc    <= '0;
      r_cause  <= EXP_NONE;
      r_int_en <= 1'b0;
      r_pie    <= 1'b0;
    end else if (i_trap) begin
      r_epc    <= i_mem_pc;
      r_cause  <= trap_cause(i_mem_exp);
      r_pie    <= r_int_en;
      r_int_en <= 1'b0;
    end else if (i_eret) begin
      r_int_en <= r_pie;
    end else if (i_cr_we) begin
      case (i_cr_addr)
        CR_STATUS: r_int_en <= i_cr_wdata[0];
        CR_EPC:    r_epc    <= ADDR_W'(i_cr_wdata);
        default:   ;
      endcase
    end
  end

  always_comb begin
    o_cr_rdata = '0;
    if (!i_rst) begin
      case (i_cr_addr)
        CR_STATUS: o_cr_rdata = {31'b0, r_int_en};
        CR_EPC:    o_cr_rdata = 32'(r_epc);
        CR_CAUSE:  o_cr_rdata = {29'b0, r_cause};
        default:   o_cr_rdata = '0;
      endcase
    end
  end

  assign o_epc    = r_epc;
  assign o_int_en = r_int_en;

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: resolves stall/flush/redirect priority for the
// IF/ID/EX/MEM stage registers and sequences trap/eret through a drain state.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(32'h0000_0100),
  parameter logic [ADDR_W-1:0] RST_VECTOR = ADDR_W'(32'h0000_0000)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_busy,
  input  logic              i_mem_busy,
  input  logic              i_ld_hazard,
  input  logic              i_mem_en,
  input  logic [ADDR_W-1:0] i_mem_pc,
  input  logic [2:0]        i_mem_exp,
  input  logic              i_mem_eret,
  input  logic              i_irq,
  input  logic              i_cr_we,
  input  logic [1:0]        i_cr_addr,
  input  logic [31:0]       i_cr_wdata,
  output logic [31:0]       o_cr_rdata,
  output logic              o_if_stall,
  output logic              o_id_stall,
  output logic              o_ex_stall,
  output logic              o_mem_stall,
  output logic              o_if_flush,
  output logic              o_id_flush,
  output logic              o_ex_flush,
  output logic              o_mem_flush,
  output logic [ADDR_W-1:0] o_new_pc,
  output logic              o_int_en
);

  state_t            r_state;
  state_t            w_state_next;
  stage_ctrl_t       w_ctrl;
  logic [ADDR_W-1:0] w_new_pc;
  logic [ADDR_W-1:0] w_epc;
  logic              w_int_en;
  logic              w_trap_req;
  logic              w_eret_req;
  logic              w_take_trap;
  logic              w_take_eret;
  logic              w_cr_commit;

  // In DRAIN the MEM-stage insn is a squashed leftover, so it may not trap or eret.
  assign w_trap_req = (r_state == ST_RUN) && i_mem_en &&
                      ((i_mem_exp != EXP_NONE) || (i_irq && w_int_en));
  assign w_eret_req = (r_state == ST_RUN) && i_mem_en && i_mem_eret;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ctrl       = '0;
    w_new_pc     = EXC_VECTOR;
    w_take_trap  = 1'b0;
    w_take_eret  = 1'b0;
    w_cr_commit  = 1'b0;
    if (i_rst) begin
      w_ctrl.flush = 4'b1111;
      w_new_pc     = RST_VECTOR;
      w_state_next = ST_RUN;
    end else if (i_mem_busy) begin
      w_ctrl.stall = 4'b1111;
    end else if (w_trap_req) begin
      w_ctrl.flush = 4'b1111;
      w_new_pc     = EXC_VECTOR;
      w_take_trap  = 1'b1;
      w_state_next = ST_DRAIN;
    end else if (w_eret_req) begin
      w_ctrl.flush = 4'b1111;
      w_new_pc     = w_epc;
      w_take_eret  = 1'b1;
      w_state_next = ST_DRAIN;
    end else begin
      w_cr_commit  = i_cr_we;
      w_state_next = ST_RUN;
      if (i_ld_hazard) begin
        w_ctrl.stall = 4'b1100;
        w_ctrl.flush = 4'b0010;
      end else if (i_if_busy) begin
        w_ctrl.stall = 4'b1000;
        w_ctrl.flush = 4'b0100;
      end
    end
  end

  pipe_ctrl_cr #(
    .ADDR_W(ADDR_W)
  ) u_cr (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_trap    (w_take_trap),
    .i_eret    (w_take_eret),
    .i_mem_exp (i_mem_exp),
    .i_mem_pc  (i_mem_pc),
    .i_cr_we   (w_cr_commit),
    .i_cr_addr (i_cr_addr),
    .i_cr_wdata(i_cr_wdata),
    .o_epc     (w_epc),
    .o_int_en  (w_int_en),
    .o_cr_rdata(o_cr_rdata)
  );

  assign o_if_stall  = w_ctrl.stall[3];
  assign o_id_stall  = w_ctrl.stall[2];
  assign o_ex_stall  = w_ctrl.stall[1];
  assign o_mem_stall = w_ctrl.stall[0];
  assign o_if_flush  = w_ctrl.flush[3];
  assign o_id_flush  = w_ctrl.flush[2];
  assign o_ex_flush  = w_ctrl.flush[1];
  assign o_mem_flush = w_ctrl.flush[0];
  assign o_new_pc    = w_new_pc;
  assign o_int_en    = w_int_en;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios with literal checks,
// then randomized traffic compared against a behavioural model every cycle.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifBusy = 1'b0, memBusy = 1'b0, ldHazard = 1'b0, memEn = 1'b0;
  logic [31:0] memPc = '0;
  logic [2:0]  memExp = '0;
  logic        memEret = 1'b0, irq = 1'b0, crWe = 1'b0;
  logic [1:0]  crAddr = '0;
  logic [31:0] crWdata = '0;
  logic [31:0] crRdata;
  logic        ifStall, idStall, exStall, memStall;
  logic        ifFlush, idFlush, exFlush, memFlush;
  logic [31:0] newPc;
  logic        intEn;

  int vectors = 0;
  int miscompares = 0;

  // Architectural model state
  logic [31:0] mEpc = '0;
  logic [2:0]  mCause = '0;
  logic        mIe = 1'b0, mPie = 1'b0, mDraining = 1'b0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_if_busy(ifBusy), .i_mem_busy(memBusy),
    .i_ld_hazard(ldHazard), .i_mem_en(memEn), .i_mem_pc(memPc), .i_mem_exp(memExp),
    .i_mem_eret(memEret), .i_irq(irq), .i_cr_we(crWe), .i_cr_addr(crAddr),
    .i_cr_wdata(crWdata), .o_cr_rdata(crRdata),
    .o_if_stall(ifStall), .o_id_stall(idStall), .o_ex_stall(exStall), .o_mem_stall(memStall),
    .o_if_flush(ifFlush), .o_id_flush(idFlush), .o_ex_flush(exFlush), .o_mem_flush(memFlush),
    .o_new_pc(newPc), .o_int_en(intEn)
  );

  task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic trapNow();
    return !mDraining && memEn && (memExp != 3'd0 || (irq && mIe));
  endfunction

  function automatic logic eretNow();
    return !mDraining && memEn && memEret;
  endfunction

  // Compare every DUT output against what the priority rules demand this cycle.
  task automatic checkOutput();
    logic [3:0]  expStall;
    logic [3:0]  expFlush;
    logic [31:0] expPc;
    logic [31:0] expRd;
    expStall = 4'b0000;
    expFlush = 4'b0000;
    expPc    = 32'h0;
    if (rst) begin
      expFlush = 4'b1111;
      expPc    = 32'h0;
    end else if (memBusy) begin
      expStall = 4'b1111;
    end else if (trapNow()) begin
      expFlush = 4'b1111;
      expPc    = 32'h100;
    end else if (eretNow()) begin
      expFlush = 4'b1111;
      expPc    = mEpc;
    end else if (ldHazard) begin
      expStall = 4'b1100;
      expFlush = 4'b0010;
    end else if (ifBusy) begin
      expStall = 4'b1000;
      expFlush = 4'b0100;
    end
    case (crAddr)
      2'd0:    expRd = {31'b0, mIe};
      2'd1:    expRd = mEpc;
      2'd2:    expRd = {29'b0, mCause};
      default: expRd = 32'h0;
    endcase
    if (rst) expRd = 32'h0;
    compare("stalls", {28'b0, ifStall, idStall, exStall, memStall}, {28'b0, expStall});
    compare("flushes", {28'b0, ifFlush, idFlush, exFlush, memFlush}, {28'b0, expFlush});
    if (expFlush[3]) compare("new_pc", newPc, expPc);
    compare("int_en", {31'b0, intEn}, {31'b0, mIe});
    compare("cr_rdata", crRdata, expRd);
  endtask

  // Advance the model by one clock edge using the inputs held this cycle.
  task automatic updateModel();
    if (rst) begin
      mEpc = '0; mCause = '0; mIe = 1'b0; mPie = 1'b0; mDraining = 1'b0;
    end else if (memBusy) begin
    end else if (trapNow()) begin
      mEpc      = memPc;
      mCause    = (memExp != 3'd0) ? memExp : 3'd7;
      mPie      = mIe;
      mIe       = 1'b0;
      mDraining = 1'b1;
    end else if (eretNow()) begin
      mIe       = mPie;
      mDraining = 1'b1;
    end else begin
      mDraining = 1'b0;
      if (crWe && crAddr == 2'd0) mIe = crWdata[0];
      if (crWe && crAddr == 2'd1) mEpc = crWdata;
    end
  endtask

  // Drive one cycle of inputs, check mid-cycle, then step the model.
  task automatic applyStimulus(input logic r, input logic ifb, input logic mb, input logic ld,
                               input logic men, input logic [31:0] pc, input logic [2:0] ex,
                               input logic er, input logic iq, input logic we,
                               input logic [1:0] ad, input logic [31:0] wd);
    @(posedge clk);
    #1;
    rst = r; ifBusy = ifb; memBusy = mb; ldHazard = ld; memEn = men; memPc = pc;
    memExp = ex; memEret = er; irq = iq; crWe = we; crAddr = ad; crWdata = wd;
    #4;
    checkOutput();
    updateModel();
  endtask

  task automatic idle(input logic [1:0] ad);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 3'd0, 0, 0, 0, ad, 32'h0);
  endtask

  initial begin
    // Reset held two cycles
    applyStimulus(1, 0, 0, 0, 0, 32'h0, 3'd0, 0, 0, 0, 2'd1, 32'h0);
    applyStimulus(1, 1, 1, 1, 1, 32'h0, 3'd2, 0, 0, 0, 2'd1, 32'h0);
    compare("rst_flush", {28'b0, ifFlush, idFlush, exFlush, memFlush}, 32'hF);
    compare("rst_new_pc", newPc, 32'h0);
    idle(2'd1);
    compare("post_rst_epc", crRdata, 32'h0);
    compare("post_rst_int_en", {31'b0, intEn}, 32'h0);
    compare("post_rst_stalls", {28'b0, ifStall, idStall, exStall, memStall}, 32'h0);

    // Alignment exception, then a second exception squashed during drain
    applyStimulus(0, 0, 0, 0, 1, 32'h40, 3'd2, 0, 0, 0, 2'd0, 32'h0);
    compare("exc_new_pc", newPc, 32'h100);
    applyStimulus(0, 0, 0, 0, 1, 32'h44, 3'd3, 0, 0, 0, 2'd1, 32'h0);
    compare("drain_no_flush", {28'b0, ifFlush, idFlush, exFlush, memFlush}, 32'h0);
    compare("exc_epc", crRdata, 32'h40);
    idle(2'd2);
    compare("exc_cause", crRdata, 32'h2);

    // Enable interrupts, then an interrupt held off by mem_busy
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 3'd0, 0, 0, 1, 2'd0, 32'h1);
    idle(2'd0);
    compare("int_en_set", {31'b0, intEn}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 0, 1, 32'h88, 3'd0, 0, 1, 0, 2'd0, 32'h0);
      compare("busy_stalls", {28'b0, ifStall, idStall, exStall, memStall}, 32'hF);
    end
    applyStimulus(0, 0, 0, 0, 1, 32'h88, 3'd0, 0, 1, 0, 2'd0, 32'h0);
    compare("irq_new_pc", newPc, 32'h100);
    idle(2'd1);
    compare("irq_epc", crRdata, 32'h88);
    compare("irq_int_en", {31'b0, intEn}, 32'h0);
    idle(2'd2);
    compare("irq_cause", crRdata, 32'h7);

    // eret restores the saved enable
    applyStimulus(0, 0, 0, 0, 1, 32'h200, 3'd0, 1, 0, 0, 2'd0, 32'h0);
    compare("eret_new_pc", newPc, 32'h88);
    compare("eret_flush", {28'b0, ifFlush, idFlush, exFlush, memFlush}, 32'hF);
    idle(2'd0);
    compare("eret_int_en", {31'b0, intEn}, 32'h1);

    // Load-use hazard beats fetch wait
    applyStimulus(0, 1, 0, 1, 0, 32'h0, 3'd0, 0, 0, 0, 2'd0, 32'h0);
    compare("ld_if_stall", {30'b0, ifStall, idStall}, 32'h3);
    compare("ld_ex_flush", {30'b0, exFlush, idFlush}, 32'h2);

    // Status write collides with a trap: trap wins
    applyStimulus(1, 0, 0, 0, 0, 32'h0, 3'd0, 0, 0, 0, 2'd0, 32'h0);
    applyStimulus(0, 0, 0, 0, 1, 32'h60, 3'd1, 0, 0, 1, 2'd0, 32'h1);
    compare("coll_new_pc", newPc, 32'h100);
    idle(2'd0);
    compare("coll_int_en", {31'b0, intEn}, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      applyStimulus($urandom_range(0, 99) < 3,
                    $urandom_range(0, 99) < 30,
                    $urandom_range(0, 99) < 25,
                    $urandom_range(0, 99) < 20,
                    $urandom_range(0, 99) < 70,
                    {$urandom_range(0, 255), 2'b00} + 32'h0,
                    ($urandom_range(0, 99) < 20) ? 3'($urandom_range(1, 7)) : 3'd0,
                    $urandom_range(0, 99) < 15,
                    $urandom_range(0, 99) < 35,
                    $urandom_range(0, 99) < 25,
                    2'($urandom_range(0, 3)),
                    $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
